// File: rtl/wb_queue.sv
// wb_queue: multi-channel register-file write-back queue.
// Accepts up to NUM_CH write requests per cycle and drops requests with we=0 or
// address 0. Surviving requests are buffered in order in a circular queue, and
// one write per cycle is retired through registered regfile outputs. When the
// queue is empty at the edge, the oldest survivor bypasses the queue.
// Optional macro WB_QUEUE_FWD_EN adds a combinational forwarding lookup port.
module wb_queue #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    parameter int AW     = 5,
    parameter int DW     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH-1:0]    in_we,
    input  logic [NUM_CH*AW-1:0] in_waddr,
    input  logic [NUM_CH*DW-1:0] in_wdata,
    output logic                 in_ready,
    output logic                 RFWe,
    output logic [AW-1:0]        rfwaddr,
    output logic [DW-1:0]        rfwdata,
    output logic                 busy
`ifdef WB_QUEUE_FWD_EN
    ,
    input  logic [AW-1:0]        fwd_raddr,
    output logic                 fwd_hit,
    output logic [DW-1:0]        fwd_data
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]     mem_addr [DEPTH];
    logic [DW-1:0]     mem_data [DEPTH];
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     head_next;
    logic [PW-1:0]     tail_next;
    logic [NUM_CH-1:0] surv;
    logic [NUM_CH-1:0] push_en;
    logic [AW-1:0]     push_addr [NUM_CH];
    logic [DW-1:0]     push_data [NUM_CH];
    logic [PW-1:0]     wr_idx [NUM_CH];
    logic [AW-1:0]     first_addr;
    logic [DW-1:0]     first_data;
    logic              pop;
    logic              bypass;
    int                n_surv;
    int                n_push;
    int                rank;

    // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    // Ready depends only on registered occupancy, never on in_valid.
    assign in_ready = (DEPTH - int'(count)) >= NUM_CH;
    assign busy     = (count != '0) || RFWe;

    // Filter, compact survivors in channel order, pick bypass and queue slots.
    always_comb begin
        pop        = (count != '0);
        surv       = '0;
        push_en    = '0;
        n_surv     = 0;
        rank       = 0;
        first_addr = '0;
        first_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            push_addr[i] = '0;
            push_data[i] = '0;
            wr_idx[i]    = ptr_add(tail, i);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            surv[i] = in_ready && in_valid[i] && in_we[i] && (in_waddr[i*AW +: AW] != '0);
            if (surv[i]) n_surv = n_surv + 1;
        end
        bypass = !pop && (n_surv > 0);
        n_push = bypass ? (n_surv - 1) : n_surv;
        for (int i = 0; i < NUM_CH; i++) begin
            if (surv[i]) begin
                if (bypass && (rank == 0)) begin
                    first_addr = in_waddr[i*AW +: AW];
                    first_data = in_wdata[i*DW +: DW];
                end else begin
                    for (int j = 0; j < NUM_CH; j++) begin
                        if (j == (bypass ? rank - 1 : rank)) begin
                            push_addr[j] = in_waddr[i*AW +: AW];
                            push_data[j] = in_wdata[i*DW +: DW];
                            push_en[j]   = 1'b1;
                        end
                    end
                end
                rank = rank + 1;
            end
        end
        head_next  = pop ? ptr_add(head, 1) : head;
        tail_next  = ptr_add(tail, n_push);
        count_next = CW'(int'(count) + n_push - (pop ? 1 : 0));
    end

    // Queue bookkeeping and the registered regfile write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            head    <= '0;
            tail    <= '0;
            RFWe    <= 1'b0;
            rfwaddr <= '0;
            rfwdata <= '0;
        end else begin
            if (pop) begin
                RFWe    <= 1'b1;
                rfwaddr <= mem_addr[head];
                rfwdata <= mem_data[head];
            end else if (bypass) begin
                RFWe    <= 1'b1;
                rfwaddr <= first_addr;
                rfwdata <= first_data;
            end else begin
                RFWe    <= 1'b0;
            end
            count <= count_next;
            head  <= head_next;
            tail  <= tail_next;
        end
    end

    // Entry storage; validity is tracked by head/count, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_CH; j++) begin
            if (push_en[j]) begin
                mem_addr[wr_idx[j]] <= push_addr[j];
                mem_data[wr_idx[j]] <= push_data[j];
            end
        end
    end

`ifdef WB_QUEUE_FWD_EN
    // Youngest-match lookup: output register first, then queue oldest to youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_raddr != '0) begin
            if (RFWe && (rfwaddr == fwd_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = rfwdata;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if ((k < int'(count)) && (mem_addr[ptr_add(head, k)] == fwd_raddr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = mem_data[ptr_add(head, k)];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: scoreboard bench for wb_queue.
// Stimulus pushes expected regfile writes into a queue; a negedge monitor pops
// and compares whenever RFWe is high.
module tb_wb_queue;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;
    localparam int AW     = 5;
    localparam int DW     = 32;

    logic                 clk;
    logic                 reset;
    logic [NUM_CH-1:0]    in_valid;
    logic [NUM_CH-1:0]    in_we;
    logic [NUM_CH*AW-1:0] in_waddr;
    logic [NUM_CH*DW-1:0] in_wdata;
    logic                 in_ready;
    logic                 RFWe;
    logic [AW-1:0]        rfwaddr;
    logic [DW-1:0]        rfwdata;
    logic                 busy;
`ifdef WB_QUEUE_FWD_EN
    logic [AW-1:0]        fwd_raddr;
    logic                 fwd_hit;
    logic [DW-1:0]        fwd_data;
`endif

    int vectors;
    int miscompares;
    int ready_dropped;
    logic [AW+DW-1:0] sb [$];

    wb_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_we    (in_we),
        .in_waddr (in_waddr),
        .in_wdata (in_wdata),
        .in_ready (in_ready),
        .RFWe     (RFWe),
        .rfwaddr  (rfwaddr),
        .rfwdata  (rfwdata),
        .busy     (busy)
`ifdef WB_QUEUE_FWD_EN
        ,
        .fwd_raddr(fwd_raddr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
`endif
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one request pair, hold until accepted, record expected retirements.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we,
                                 input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int waited;
        in_valid = v;
        in_we    = we;
        in_waddr = {a1, a0};
        in_wdata = {d1, d0};
        waited   = 0;
        while (!in_ready && waited < 20) begin
            ready_dropped = 1;
            @(posedge clk);
            #1;
            waited = waited + 1;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            if (v[0] && we[0] && a0 != '0) sb.push_back({a0, d0});
            if (v[1] && we[1] && a1 != '0) sb.push_back({a1, d1});
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        in_we    = '0;
        in_waddr = '0;
        in_wdata = '0;
    endtask

    task automatic waitIdle(input string name);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checkOutput(name, 64'(busy), 64'd0);
    endtask

    // Monitor: every retirement must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && RFWe) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_write", {27'd0, rfwaddr, rfwdata}, 64'd0);
            end else begin
                checkOutput("retire", {27'd0, rfwaddr, rfwdata}, {27'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        ready_dropped = 0;
        reset    = 1'b0;
        in_valid = '0;
        in_we    = '0;
        in_waddr = '0;
        in_wdata = '0;
`ifdef WB_QUEUE_FWD_EN
        fwd_raddr = 5'd3;
`endif
        #22 reset = 1'b1;
        #1;
        checkOutput("reset_rfwe",    64'(RFWe),     64'd0);
        checkOutput("reset_rfwaddr", 64'(rfwaddr),  64'd0);
        checkOutput("reset_rfwdata", 64'(rfwdata),  64'd0);
        checkOutput("reset_ready",   64'(in_ready), 64'd1);
        checkOutput("reset_busy",    64'(busy),     64'd0);

        // Single request: visible for exactly one cycle after acceptance.
        @(posedge clk);
        #1;
        applyStimulus(2'b01, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("single_rfwe_t1", 64'(RFWe), 64'd1);
        @(negedge clk);
        checkOutput("single_rfwe_t2", 64'(RFWe), 64'd0);
        checkOutput("single_busy_t2", 64'(busy), 64'd0);
        checkOutput("single_addr_hold", 64'(rfwaddr), 64'd5);

        // Both channels, four pairs back to back: ready must stall once.
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            applyStimulus(2'b11, 2'b11, AW'(2*p+1), 32'h100 + 32'(2*p+1),
                                        AW'(2*p+2), 32'h100 + 32'(2*p+2));
        end
        checkOutput("burst_ready_dropped", 64'(ready_dropped), 64'd1);
        waitIdle("burst_drain");

        // Filtered requests: address 0 and we=0 both disappear.
        @(posedge clk);
        #1;
        applyStimulus(2'b11, 2'b01, 5'd0, 32'hAAAA, 5'd7, 32'hBBBB);
        checkOutput("filter_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        checkOutput("filter_rfwe", 64'(RFWe), 64'd0);
        checkOutput("filter_busy", 64'(busy), 64'd0);

        // Same-address pair: older channel retires first.
        @(posedge clk);
        #1;
        applyStimulus(2'b11, 2'b11, 5'd3, 32'h11, 5'd3, 32'h22);
`ifdef WB_QUEUE_FWD_EN
        checkOutput("fwd_hit",  64'(fwd_hit),  64'd1);
        checkOutput("fwd_data", 64'(fwd_data), 64'h22);
`endif
        waitIdle("same_addr_drain");

        // Fill to three entries, then pulse reset between edges.
        @(posedge clk);
        #1;
        applyStimulus(2'b11, 2'b11, 5'd10, 32'hA0, 5'd11, 32'hA1);
        applyStimulus(2'b11, 2'b11, 5'd12, 32'hA2, 5'd13, 32'hA3);
        applyStimulus(2'b11, 2'b11, 5'd14, 32'hA4, 5'd15, 32'hA5);
        checkOutput("full_ready", 64'(in_ready), 64'd0);
        checkOutput("full_busy",  64'(busy),     64'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        checkOutput("midreset_rfwe", 64'(RFWe), 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        #9;
        reset = 1'b1;
        #1;
        checkOutput("release_ready", 64'(in_ready), 64'd1);
        checkOutput("release_busy",  64'(busy),     64'd0);
        repeat (4) @(negedge clk);
        checkOutput("release_idle_rfwe", 64'(RFWe), 64'd0);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
